// File: rtl/io_uart_pkg.sv
// rtl/io_uart_pkg.sv - shared types and constants for the memory-mapped UART transmitter
package io_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam logic [1:0] IO_TXDATA = 2'b00;
    localparam logic [1:0] IO_CTRL   = 2'b01;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_OVF_CLR = 1;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    function automatic logic [31:0] status_word(
        input logic       busy,
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic [7:0] count
    );
        logic [31:0] w;
        w                     = '0;
        w[STAT_BUSY]          = busy;
        w[STAT_EMPTY]         = empty;
        w[STAT_FULL]          = full;
        w[STAT_OVF]           = ovf;
        w[STAT_CNT_LSB +: 8]  = count;
        return w;
    endfunction

endpackage

// File: rtl/io_uart_tx_fifo.sv
// rtl/io_uart_tx_fifo.sv - synchronous FIFO with flush; pushes when full and pops when empty are ignored
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign count = cnt_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push & ~full & ~flush;
        pop_ok   = pop & ~empty & ~flush;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        // Flush overrides any concurrent pop and leaves the FIFO empty.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - store-mapped 8N1 UART transmitter with FIFO and combinational status word
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_rw,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_datain,
    output logic [31:0] io_dataout,
    output logic        uart_txd,
    output logic        tx_busy
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              ovf_q, ovf_d;

    logic              push_req, ctrl_wr, flush, ovf_clr;
    logic              fifo_pop, fifo_empty, fifo_full, can_pop, baud_end;
    logic [7:0]        fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_bits;

    assign unused_bits = ^{io_addr[31:2], io_datain[31:8]};

    always_comb begin
        push_req = io_rw & (io_addr[1:0] == IO_TXDATA);
        ctrl_wr  = io_rw & (io_addr[1:0] == IO_CTRL);
        flush    = ctrl_wr & io_datain[CTRL_FLUSH];
        ovf_clr  = ctrl_wr & io_datain[CTRL_OVF_CLR];
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .flush (flush),
        .wdata (io_datain[7:0]),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // A full FIFO drops the push even if the FSM frees a slot this cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (push_req & fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        baud_end  = (baud_q == BAUD_LAST);
        can_pop   = ~fifo_empty & ~flush;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (can_pop) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit so frames stay contiguous.
                if (baud_end) begin
                    baud_d = '0;
                    if (can_pop) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase

        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign uart_txd   = txd_q;
    assign tx_busy    = (state_q != ST_IDLE) | ~fifo_empty;
    assign io_dataout = status_word(tx_busy, fifo_empty, fifo_full, ovf_q, 8'(fifo_count));

endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - self-checking bench for io_uart_tx
module tb_io_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_rw = 1'b0;
    logic [31:0] io_addr = '0;
    logic [31:0] io_datain = '0;
    logic [31:0] io_dataout;
    logic        uart_txd;
    logic        tx_busy;

    always #5 clk = ~clk;

    io_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .io_rw      (io_rw),
        .io_addr    (io_addr),
        .io_datain  (io_datain),
        .io_dataout (io_dataout),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte queue plus time remaining in the frame on the line.
    byte unsigned m_q[$];
    byte unsigned m_log[$];
    bit           m_ovf = 1'b0;
    int           m_timer = 0;
    logic [7:0]   m_cur = '0;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    function automatic logic m_txd();
        if (m_timer == 0) return 1'b1;
        return frame_bit(m_cur, (FRAME - m_timer) / CPB);
    endfunction

    function automatic logic [31:0] m_status();
        int sz = m_q.size();
        bit busy = (m_timer > 0) || (sz > 0);
        return {16'h0, 8'(sz), 4'h0, m_ovf, (sz == DEPTH), (sz == 0), busy};
    endfunction

    task automatic model_step(input bit rst, input bit rw, input logic [31:0] addr, input logic [31:0] data);
        int sz;
        bit psh, ctl, fl, clr, pop;
        if (rst) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_timer = 0;
            return;
        end
        sz  = m_q.size();
        psh = rw && (addr[1:0] == 2'b00);
        ctl = rw && (addr[1:0] == 2'b01);
        fl  = ctl && data[0];
        clr = ctl && data[1];
        pop = !fl && (sz > 0) && (m_timer <= 1);
        if (pop) begin
            m_cur   = m_q.pop_front();
            m_log.push_back(m_cur);
            m_timer = FRAME;
        end else if (m_timer > 0) begin
            m_timer--;
        end
        if (fl) m_q.delete();
        if (psh) begin
            if (sz < DEPTH) m_q.push_back(data[7:0]);
            else m_ovf = 1'b1;
        end
        if (clr) m_ovf = 1'b0;
    endtask

    task automatic cycle(input bit rst, input bit rw, input logic [31:0] addr, input logic [31:0] data);
        reset     = rst;
        io_rw     = rw;
        io_addr   = addr;
        io_datain = data;
        @(posedge clk);
        model_step(rst, rw, addr, data);
        @(negedge clk);
        chk("model txd", {31'b0, uart_txd}, {31'b0, m_txd()});
        chk("model status", io_dataout, m_status());
        chk("model busy", {31'b0, tx_busy}, {31'b0, m_status()[0]});
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic push(input logic [7:0] b);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, {24'hABCDEF, b});
    endtask

    task automatic ctrl(input logic [31:0] v);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFD, v);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (tx_busy && n < limit) begin
            idle();
            n++;
        end
        chk({name, " drained"}, {31'b0, tx_busy}, 32'h0);
    endtask

    // Line decoder: finds start bits and samples mid-bit.
    byte unsigned rx_q[$];
    logic [9:0]   mon_bits;
    int           mon_cnt = 0;
    bit           mon_active = 1'b0;
    logic         mon_prev = 1'b1;

    always @(posedge clk) begin
        #2;
        if (reset) begin
            mon_active = 1'b0;
            mon_prev   = 1'b1;
        end else begin
            if (!mon_active && mon_prev && !uart_txd) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
            if (mon_active) begin
                if (mon_cnt % CPB == CPB / 2) mon_bits[mon_cnt / CPB] = uart_txd;
                mon_cnt++;
                if (mon_cnt == FRAME) begin
                    mon_active = 1'b0;
                    chk("line framing", {30'b0, mon_bits[9], mon_bits[0]}, 32'h2);
                    rx_q.push_back(mon_bits[8:1]);
                end
            end
            mon_prev = uart_txd;
        end
    end

    typedef struct {
        bit          rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_status;
        logic        exp_txd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s [2*FRAME];
        logic [7:0]  b;
        logic [9:0]  exp55;
        logic [7:0]  exp_b2b [2];
        int          r;

        vecs[0]  = '{1'b1, 32'h0, 32'h01, 32'h0000_0101, 1'b1};
        vecs[1]  = '{1'b1, 32'h0, 32'h02, 32'h0000_0101, 1'b0};
        vecs[2]  = '{1'b1, 32'h0, 32'h03, 32'h0000_0201, 1'b0};
        vecs[3]  = '{1'b1, 32'h0, 32'h04, 32'h0000_0301, 1'b0};
        vecs[4]  = '{1'b1, 32'h0, 32'h05, 32'h0000_0405, 1'b0};
        vecs[5]  = '{1'b1, 32'h0, 32'h06, 32'h0000_040D, 1'b1};
        vecs[6]  = '{1'b1, 32'h1, 32'h02, 32'h0000_0405, 1'b1};
        vecs[7]  = '{1'b0, 32'h0, 32'h00, 32'h0000_0405, 1'b1};
        vecs[8]  = '{1'b1, 32'h1, 32'h00, 32'h0000_0405, 1'b1};
        vecs[9]  = '{1'b1, 32'h2, 32'hFF, 32'h0000_0405, 1'b0};
        vecs[10] = '{1'b1, 32'h1, 32'h01, 32'h0000_0003, 1'b0};
        vecs[11] = '{1'b0, 32'h3, 32'h01, 32'h0000_0003, 1'b0};

        @(negedge clk);
        cycle(1'b1, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 32'h0);
        chk("reset txd", {31'b0, uart_txd}, 32'h1);
        chk("reset busy", {31'b0, tx_busy}, 32'h0);
        chk("reset status", io_dataout, 32'h0000_0002);
        idle();

        // Overflow, overflow clear, ignored offsets and flush.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, vecs[i].rw, vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d status", i), io_dataout, vecs[i].exp_status);
            chk($sformatf("vec%0d txd", i), {31'b0, uart_txd}, {31'b0, vecs[i].exp_txd});
        end
        wait_idle(200, "table");

        // Single byte 0x55.
        exp55 = {1'b1, 8'h55, 1'b0};
        push(8'h55);
        chk("byte55 line idle at push", {31'b0, uart_txd}, 32'h1);
        for (int k = 0; k < FRAME; k++) begin
            idle();
            chk($sformatf("byte55 sample %0d", k), {31'b0, uart_txd}, {31'b0, exp55[k / CPB]});
        end
        chk("byte55 busy through stop", {31'b0, tx_busy}, 32'h1);
        idle();
        chk("byte55 busy after frame", {31'b0, tx_busy}, 32'h0);

        // Back-to-back frames.
        rx_q.delete();
        exp_b2b[0] = 8'hA5;
        exp_b2b[1] = 8'h3C;
        push(8'hA5);
        push(8'h3C);
        s[0] = uart_txd;
        for (int k = 1; k < 2 * FRAME; k++) begin
            idle();
            s[k] = uart_txd;
        end
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) b[i] = s[f*FRAME + (i+1)*CPB + CPB/2];
            chk($sformatf("b2b byte %0d", f), {24'b0, b}, {24'b0, exp_b2b[f]});
            chk($sformatf("b2b stop %0d", f), {31'b0, s[f*FRAME + 9*CPB + CPB/2]}, 32'h1);
        end
        chk("b2b last stop sample", {31'b0, s[FRAME-1]}, 32'h1);
        chk("b2b no gap", {31'b0, s[FRAME]}, 32'h0);
        idle();
        chk("b2b busy after 80", {31'b0, tx_busy}, 32'h0);
        chk("b2b rx count", rx_q.size(), 32'd2);

        // Flush during the first frame's data bits.
        rx_q.delete();
        push(8'hFF);
        push(8'h00);
        push(8'h0F);
        repeat (7) idle();
        ctrl(32'h1);
        chk("flush status", io_dataout, 32'h0000_0003);
        wait_idle(100, "flush");
        repeat (20) idle();
        chk("flush rx count", rx_q.size(), 32'd1);
        if (rx_q.size() == 1) chk("flush rx byte", {24'b0, rx_q[0]}, 32'hFF);

        // Reset during data bit 3.
        push(8'h96);
        repeat (17) idle();
        cycle(1'b1, 1'b0, 32'h0, 32'h0);
        chk("midreset txd", {31'b0, uart_txd}, 32'h1);
        chk("midreset status", io_dataout, 32'h0000_0002);
        idle();
        rx_q.delete();
        push(8'h3C);
        wait_idle(100, "post-reset");
        chk("post-reset rx count", rx_q.size(), 32'd1);
        if (rx_q.size() == 1) chk("post-reset rx byte", {24'b0, rx_q[0]}, 32'h3C);

        // Randomised traffic against the model.
        rx_q.delete();
        m_log.delete();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 15);
            if (r < 3) push(8'($urandom));
            else if (r == 3) ctrl($urandom_range(0, 3));
            else if (r == 4) cycle(1'b0, 1'b1, {$urandom_range(0, 1) == 0 ? 30'h0 : 30'h3FFF_FFFF, 1'b1, 1'($urandom)}, $urandom);
            else idle();
        end
        wait_idle(400, "random");
        repeat (4) idle();
        chk("random rx count", rx_q.size(), m_log.size());
        for (int i = 0; i < rx_q.size() && i < m_log.size(); i++) begin
            chk($sformatf("random rx byte %0d", i), {24'b0, rx_q[i]}, {24'b0, m_log[i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
